// File: rtl/axi_lite_regfile_pkg.sv
// axi_lite_regfile_pkg: shared enums, response codes and index-width helper for axi_lite_regfile
package axi_lite_regfile_pkg;
  typedef logic [1:0] resp_t;
  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_lite_regfile_wr_join.sv
// axi_lite_regfile_wr_join: holds AW and W independently and raises commit once both are available
module axi_lite_regfile_wr_join #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic [2:0]            aw_prot_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [STRB_WIDTH-1:0] w_strb_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  busy_i,
  input  logic                  done_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [2:0]            prot_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [STRB_WIDTH-1:0] strb_o,
  output logic                  commit_o
);
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  aw_hs, w_hs;
  assign aw_ready_o = !rst_i && !busy_i && !aw_held;
  assign w_ready_o  = !rst_i && !busy_i && !w_held;
  assign aw_hs      = aw_valid_i && aw_ready_o;
  assign w_hs       = w_valid_i && w_ready_o;
  assign commit_o   = !busy_i && (aw_held || aw_hs) && (w_held || w_hs);
  assign addr_o     = aw_held ? addr_q : aw_addr_i;
  assign prot_o     = aw_held ? prot_q : aw_prot_i;
  assign data_o     = w_held ? data_q : w_data_i;
  assign strb_o     = w_held ? strb_q : w_strb_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || done_i) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= aw_addr_i;
        prot_q  <= aw_prot_i;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        data_q <= w_data_i;
        strb_q <= w_strb_i;
      end
    end
  end
endmodule

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave register file with RW/RO registers; define AXI_LITE_REGFILE_PROT_EN to reject unprivileged accesses
module axi_lite_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL = '0,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic [2:0]                     aw_prot_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [STRB_WIDTH-1:0]          w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic [2:0]                     ar_prot_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]            reg_wr_o,
  input  logic [NUM_REGS-1:0]            hw_we_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_d_i
);
  localparam int ALIGN = $clog2(STRB_WIDTH);
  localparam int IW = idx_width(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS * STRB_WIDTH);
  wr_state_e             wr_state;
  rd_state_e             rd_state;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_prot;
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic                  commit, wr_ok, wr_oor, rd_oor, ar_hs, b_done;
  resp_t                 wr_resp, rd_resp;
  axi_lite_regfile_wr_join #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_join (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .aw_addr_i (aw_addr_i),
    .aw_prot_i (aw_prot_i),
    .aw_valid_i(aw_valid_i),
    .aw_ready_o(aw_ready_o),
    .w_data_i  (w_data_i),
    .w_strb_i  (w_strb_i),
    .w_valid_i (w_valid_i),
    .w_ready_o (w_ready_o),
    .busy_i    (wr_state == WR_RESP),
    .done_i    (b_done),
    .addr_o    (wr_addr),
    .prot_o    (wr_prot),
    .data_o    (wr_data),
    .strb_o    (wr_strb),
    .commit_o  (commit)
  );
  assign b_valid_o  = !rst_i && wr_state == WR_RESP;
  assign r_valid_o  = !rst_i && rd_state == RD_RESP;
  assign ar_ready_o = !rst_i && rd_state == RD_IDLE;
  assign b_done     = b_valid_o && b_ready_i;
  assign ar_hs      = ar_valid_i && ar_ready_o;
  assign wr_idx     = wr_addr[ALIGN +: IW];
  assign rd_idx     = ar_addr_i[ALIGN +: IW];
  assign wr_oor     = {1'b0, wr_addr} >= LIMIT;
  assign rd_oor     = {1'b0, ar_addr_i} >= LIMIT;
  assign wr_ok      = commit && wr_resp == RESP_OKAY;
  always_comb begin
    wr_resp = wr_oor ? RESP_DECERR : RO_MASK[wr_idx] ? RESP_SLVERR : RESP_OKAY;
    rd_resp = rd_oor ? RESP_DECERR : RESP_OKAY;
`ifdef AXI_LITE_REGFILE_PROT_EN
    if (wr_resp == RESP_OKAY && !wr_prot[0]) wr_resp = RESP_SLVERR;
    if (rd_resp == RESP_OKAY && !ar_prot_i[0]) rd_resp = RESP_SLVERR;
`endif
    rd_data = rd_resp == RESP_OKAY ? regs[rd_idx] : '0;
  end
`ifdef AXI_LITE_REGFILE_PROT_EN
  logic unused_prot;
  assign unused_prot = ^{wr_prot[2:1], ar_prot_i[2:1]};
`else
  logic unused_prot;
  assign unused_prot = ^{wr_prot, ar_prot_i};
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state <= WR_IDLE;
      b_resp_o <= RESP_OKAY;
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= NUM_REGS'(wr_ok) << wr_idx;
      if (commit) begin
        wr_state <= WR_RESP;
        b_resp_o <= wr_resp;
      end else if (b_done) begin
        wr_state <= WR_IDLE;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state <= RD_IDLE;
      r_data_o <= '0;
      r_resp_o <= RESP_OKAY;
    end else if (ar_hs) begin
      rd_state <= RD_RESP;
      r_data_o <= rd_data;
      r_resp_o <= rd_resp;
    end else if (r_valid_o && r_ready_i) begin
      rd_state <= RD_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst_i) begin
        regs[i] <= RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (RO_MASK[i] && hw_we_i[i]) begin
        regs[i] <= hw_d_i[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (wr_ok && wr_idx == IW'(i)) begin
        for (int b = 0; b < STRB_WIDTH; b++)
          if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
endmodule
